// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the 1024x768 @ 65 MHz VGA path.
//   H_ACTIVE / V_ACTIVE : visible pixels per line / visible lines per frame
//   COORD_W             : width of the coordinate outputs
//   POS_W / CMP_W       : internal position width and wall-compare width
//                         (one extra bit so pos + size + step cannot wrap)
//   state_t             : rectangle motion state (IDLE, RUN, PAUSE)
//   dir_t               : travel direction along one axis
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;
  localparam int COORD_W  = 20;
  localparam int POS_W    = 12;
  localparam int CMP_W    = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

endpackage

// File: rtl/axis_bounce.sv
// ---------------------------------------------------------------------------
// axis_bounce
// Combinational one-axis step with wall bounce. Used once for X, once for Y.
//   pos      in  : current low edge (x1 or y1)
//   dir      in  : current direction
//   step     in  : pixels moved per frame tick
//   size     in  : rectangle extent along this axis
//   limit    in  : number of visible pixels/lines along this axis
//   pos_next out : low edge after this tick
//   dir_next out : direction after this tick
//   hit      out : a wall was reached on this tick
// ---------------------------------------------------------------------------
module axis_bounce
  import vga_pkg::*;
(
  input  logic [POS_W-1:0] pos,
  input  dir_t             dir,
  input  logic [POS_W-1:0] step,
  input  logic [POS_W-1:0] size,
  input  logic [CMP_W-1:0] limit,
  output logic [POS_W-1:0] pos_next,
  output dir_t             dir_next,
  output logic             hit
);

  logic [CMP_W-1:0] far_edge;
  logic [CMP_W-1:0] last_pix;
  logic [CMP_W-1:0] clamp_pos;

  always_comb begin
    // far edge after a forward step, widened so it can exceed the screen
    far_edge  = {1'b0, pos} + {1'b0, size} + {1'b0, step};
    last_pix  = limit - {{(CMP_W-1){1'b0}}, 1'b1};
    clamp_pos = last_pix - {1'b0, size};

    pos_next = pos;
    dir_next = dir;
    hit      = 1'b0;

    if (dir == DIR_POS) begin
      if (far_edge > last_pix) begin
        // park the far edge exactly on the last visible pixel
        pos_next = clamp_pos[POS_W-1:0];
        dir_next = DIR_NEG;
        hit      = 1'b1;
      end else begin
        pos_next = pos + step;
      end
    end else begin
      if (pos < step) begin
        pos_next = '0;
        dir_next = DIR_POS;
        hit      = 1'b1;
      end else begin
        pos_next = pos - step;
      end
    end
  end

endmodule

// File: rtl/rect_motion.sv
// ---------------------------------------------------------------------------
// rect_motion
// Bouncing-rectangle corner generator feeding vga_game. Coordinates change
// only on the frame tick raised on the first vertical-blanking line, so the
// rectangle never tears on screen.
//   clk_65M    in  : pixel clock
//   clear      in  : asynchronous active-low reset
//   game_on    in  : 1 = run, 0 = pause
//   game_start in  : restart request (rising edge)
//   H_cnt      in  : horizontal counter from vga_ctrl
//   V_cnt      in  : vertical counter from vga_ctrl
//   x1/x2      out : left/right edge, registered, x2 = x1 + RECT_W
//   y1/y2      out : top/bottom edge, registered, y2 = y1 + RECT_H
//   moving     out : high while the state is RUN
//   bounce     out : one-cycle pulse when a step hit any wall
// Optional build macro RECT_MOTION_SYNC_EN: game_on and game_start pass
// through two-flop synchronizers first (2 extra cycles of response).
// RECT_W < H_ACTIVE and RECT_H < V_ACTIVE must hold.
// ---------------------------------------------------------------------------
module rect_motion
  import vga_pkg::*;
#(
  parameter int RECT_W = 600,
  parameter int RECT_H = 200,
  parameter int INIT_X = 200,
  parameter int INIT_Y = 200,
  parameter int STEP_X = 4,
  parameter int STEP_Y = 2
) (
  input  logic               clk_65M,
  input  logic               clear,
  input  logic               game_on,
  input  logic               game_start,
  input  logic [16:0]        H_cnt,
  input  logic [16:0]        V_cnt,
  output logic [COORD_W-1:0] x1,
  output logic [COORD_W-1:0] x2,
  output logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] y2,
  output logic               moving,
  output logic               bounce
);

  localparam logic [POS_W-1:0] RECT_W_P = POS_W'(RECT_W);
  localparam logic [POS_W-1:0] RECT_H_P = POS_W'(RECT_H);
  localparam logic [POS_W-1:0] INIT_X_P = POS_W'(INIT_X);
  localparam logic [POS_W-1:0] INIT_Y_P = POS_W'(INIT_Y);
  localparam logic [POS_W-1:0] STEP_X_P = POS_W'(STEP_X);
  localparam logic [POS_W-1:0] STEP_Y_P = POS_W'(STEP_Y);
  localparam logic [CMP_W-1:0] H_LIM    = CMP_W'(H_ACTIVE);
  localparam logic [CMP_W-1:0] V_LIM    = CMP_W'(V_ACTIVE);

  logic game_on_i;
  logic game_start_i;

`ifdef RECT_MOTION_SYNC_EN
  logic [1:0] on_sync_reg;
  logic [1:0] start_sync_reg;

  always_ff @(posedge clk_65M or negedge clear) begin
    if (!clear) begin
      on_sync_reg    <= 2'b00;
      start_sync_reg <= 2'b00;
    end else begin
      on_sync_reg    <= {on_sync_reg[0], game_on};
      start_sync_reg <= {start_sync_reg[0], game_start};
    end
  end

  assign game_on_i    = on_sync_reg[1];
  assign game_start_i = start_sync_reg[1];
`else
  assign game_on_i    = game_on;
  assign game_start_i = game_start;
`endif

  state_t           state_reg, state_next;
  logic             game_start_q;
  logic             tick_q;
  logic             start_rise;
  logic             do_load, do_move;
  logic [POS_W-1:0] x1_reg, x2_reg, y1_reg, y2_reg;
  dir_t             dx_reg, dy_reg;
  logic             bounce_reg;
  logic [POS_W-1:0] x1_step, y1_step;
  dir_t             dx_step, dy_step;
  logic             hit_x, hit_y;

  assign start_rise = game_start_i & ~game_start_q;

  // edge-detect register and one-cycle frame tick on the first blanking line
  always_ff @(posedge clk_65M or negedge clear) begin
    if (!clear) begin
      game_start_q <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      game_start_q <= game_start_i;
      tick_q       <= (H_cnt == 17'd0) && (V_cnt == 17'(V_ACTIVE));
    end
  end

  // state register
  always_ff @(posedge clk_65M or negedge clear) begin
    if (!clear) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // next-state logic: restart beats pause beats everything else
  always_comb begin
    state_next = state_reg;
    if (start_rise) begin
      state_next = game_on_i ? RUN : PAUSE;
    end else begin
      case (state_reg)
        IDLE:    state_next = IDLE;
        RUN:     state_next = game_on_i ? RUN : PAUSE;
        PAUSE:   state_next = game_on_i ? RUN : PAUSE;
        default: state_next = IDLE;
      endcase
    end
  end

  // output / control decode
  always_comb begin
    moving  = (state_reg == RUN);
    do_load = start_rise;
    do_move = !start_rise && (state_reg == RUN) && game_on_i && tick_q;
  end

  axis_bounce u_axis_x (
    .pos      (x1_reg),
    .dir      (dx_reg),
    .step     (STEP_X_P),
    .size     (RECT_W_P),
    .limit    (H_LIM),
    .pos_next (x1_step),
    .dir_next (dx_step),
    .hit      (hit_x)
  );

  axis_bounce u_axis_y (
    .pos      (y1_reg),
    .dir      (dy_reg),
    .step     (STEP_Y_P),
    .size     (RECT_H_P),
    .limit    (V_LIM),
    .pos_next (y1_step),
    .dir_next (dy_step),
    .hit      (hit_y)
  );

  // position registers: far edges are written with the near edges so the
  // corner pairs can never be observed out of step
  always_ff @(posedge clk_65M or negedge clear) begin
    if (!clear) begin
      x1_reg     <= INIT_X_P;
      x2_reg     <= INIT_X_P + RECT_W_P;
      y1_reg     <= INIT_Y_P;
      y2_reg     <= INIT_Y_P + RECT_H_P;
      dx_reg     <= DIR_POS;
      dy_reg     <= DIR_POS;
      bounce_reg <= 1'b0;
    end else begin
      bounce_reg <= 1'b0;
      if (do_load) begin
        x1_reg <= INIT_X_P;
        x2_reg <= INIT_X_P + RECT_W_P;
        y1_reg <= INIT_Y_P;
        y2_reg <= INIT_Y_P + RECT_H_P;
        dx_reg <= DIR_POS;
        dy_reg <= DIR_POS;
      end else if (do_move) begin
        x1_reg     <= x1_step;
        x2_reg     <= x1_step + RECT_W_P;
        y1_reg     <= y1_step;
        y2_reg     <= y1_step + RECT_H_P;
        dx_reg     <= dx_step;
        dy_reg     <= dy_step;
        bounce_reg <= hit_x | hit_y;
      end
    end
  end

  assign x1     = {{(COORD_W-POS_W){1'b0}}, x1_reg};
  assign x2     = {{(COORD_W-POS_W){1'b0}}, x2_reg};
  assign y1     = {{(COORD_W-POS_W){1'b0}}, y1_reg};
  assign y2     = {{(COORD_W-POS_W){1'b0}}, y2_reg};
  assign bounce = bounce_reg;

endmodule

// File: tb/tb_rect_motion.sv
// ---------------------------------------------------------------------------
// tb_rect_motion
// Self-checking bench for rect_motion (default build). The VGA counters are
// driven directly: a frame event is one cycle of H_cnt = 0, V_cnt = 768.
// ---------------------------------------------------------------------------
module tb_rect_motion;

  localparam int RW = 600;
  localparam int RH = 200;
  localparam int IX = 200;
  localparam int IY = 200;
  localparam int SX = 4;
  localparam int SY = 2;
  localparam int HA = 1024;
  localparam int VA = 768;

  localparam int A_TICKS = 0;
  localparam int A_START = 1;
  localparam int A_ON    = 2;

  logic        clk_65M    = 1'b0;
  logic        clear      = 1'b0;
  logic        game_on    = 1'b0;
  logic        game_start = 1'b0;
  logic [16:0] H_cnt      = 17'd5;
  logic [16:0] V_cnt      = 17'd0;
  logic [19:0] x1, x2, y1, y2;
  logic        moving, bounce;

  int errors = 0;
  int checks = 0;

  rect_motion dut (
    .clk_65M    (clk_65M),
    .clear      (clear),
    .game_on    (game_on),
    .game_start (game_start),
    .H_cnt      (H_cnt),
    .V_cnt      (V_cnt),
    .x1         (x1),
    .x2         (x2),
    .y1         (y1),
    .y2         (y2),
    .moving     (moving),
    .bounce     (bounce)
  );

  always #5 clk_65M = ~clk_65M;

  typedef struct {
    int act;
    int arg;
    int ex1, ex2, ey1, ey2;
    int emov, ebnc;
  } vec_t;

  vec_t tbl[14];

  // behavioural model: rectangle position, velocity sign and run state
  int m_state;  // 0 idle, 1 running, 2 paused
  int mx, my, mdx, mdy;
  bit m_on;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int ex1, input int ex2,
                               input int ey1, input int ey2, input int emov,
                               input int ebnc);
    check({tag, ".x1"}, int'(x1), ex1);
    check({tag, ".x2"}, int'(x2), ex2);
    check({tag, ".y1"}, int'(y1), ey1);
    check({tag, ".y2"}, int'(y2), ey2);
    check({tag, ".moving"}, int'(moving), emov);
    check({tag, ".bounce"}, int'(bounce), ebnc);
    $display("%s: x1=%0d x2=%0d y1=%0d y2=%0d moving=%0d bounce=%0d",
             tag, x1, x2, y1, y2, moving, bounce);
  endtask

  // n frame events; returns at the sample point right after the last update
  task automatic frame_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_65M); H_cnt = 17'd0; V_cnt = 17'(VA);
      @(negedge clk_65M); H_cnt = 17'd5; V_cnt = 17'd0;
    end
    @(negedge clk_65M);
  endtask

  task automatic start_pulse();
    @(negedge clk_65M); game_start = 1'b1;
    @(negedge clk_65M); game_start = 1'b0;
  endtask

  task automatic set_on(input bit v);
    @(negedge clk_65M); game_on = v;
    @(negedge clk_65M);
  endtask

  // game_start rises in exactly the cycle the frame tick is high
  task automatic start_with_tick();
    @(negedge clk_65M); H_cnt = 17'd0; V_cnt = 17'(VA);
    @(negedge clk_65M); H_cnt = 17'd5; V_cnt = 17'd0; game_start = 1'b1;
    @(negedge clk_65M); game_start = 1'b0;
  endtask

  // one axis moving one step with wall reflection, in plain integers
  task automatic axis_move(inout int p, inout int d, input int step,
                           input int size, input int limit, output bit hit);
    hit = 1'b0;
    if (d > 0) begin
      if (p + size + step > limit - 1) begin
        p = limit - 1 - size; d = -1; hit = 1'b1;
      end else p = p + step;
    end else begin
      if (p < step) begin
        p = 0; d = 1; hit = 1'b1;
      end else p = p - step;
    end
  endtask

  task automatic model_tick(output bit hit);
    bit hx, hy;
    hit = 1'b0;
    if (m_state == 1) begin
      axis_move(mx, mdx, SX, RW, HA, hx);
      axis_move(my, mdy, SY, RH, VA, hy);
      hit = hx | hy;
    end
  endtask

  task automatic model_start();
    mx = IX; my = IY; mdx = 1; mdy = 1;
    m_state = m_on ? 1 : 2;
  endtask

  initial begin
    int r, n;
    bit h, eb;

    // directed walk through the reference scenario
    tbl[0]  = '{A_TICKS,   3, 200, 800, 200, 400, 0, 0};
    tbl[1]  = '{A_ON,      1, 200, 800, 200, 400, 0, 0};
    tbl[2]  = '{A_START,   0, 200, 800, 200, 400, 1, 0};
    tbl[3]  = '{A_TICKS,   1, 204, 804, 202, 402, 1, 0};
    tbl[4]  = '{A_TICKS,  54, 420, 1020, 310, 510, 1, 0};
    tbl[5]  = '{A_TICKS,   1, 423, 1023, 312, 512, 1, 1};
    tbl[6]  = '{A_TICKS,   1, 419, 1019, 314, 514, 1, 0};
    tbl[7]  = '{A_TICKS, 126,  84, 684, 566, 766, 1, 0};
    tbl[8]  = '{A_TICKS,   1,  88, 688, 567, 767, 1, 1};
    tbl[9]  = '{A_TICKS,   1,  92, 692, 565, 765, 1, 0};
    tbl[10] = '{A_ON,      0,  92, 692, 565, 765, 0, 0};
    tbl[11] = '{A_TICKS,   5,  92, 692, 565, 765, 0, 0};
    tbl[12] = '{A_ON,      1,  92, 692, 565, 765, 1, 0};
    tbl[13] = '{A_TICKS,   1,  96, 696, 563, 763, 1, 0};

    // reset state while clear is held
    repeat (3) @(negedge clk_65M);
    check_outputs("reset_hold", 200, 800, 200, 400, 0, 0);
    clear = 1'b1;
    @(negedge clk_65M);

    for (int i = 0; i < 14; i++) begin
      case (tbl[i].act)
        A_TICKS: frame_ticks(tbl[i].arg);
        A_START: start_pulse();
        default: set_on(tbl[i].arg[0]);
      endcase
      check_outputs($sformatf("vec%0d", i), tbl[i].ex1, tbl[i].ex2,
                    tbl[i].ey1, tbl[i].ey2, tbl[i].emov, tbl[i].ebnc);
    end

    // restart coinciding with a tick: INIT loaded, no step, dirs back to +/+
    frame_ticks(3);
    check_outputs("pre_coinc", 108, 708, 557, 757, 1, 0);
    start_with_tick();
    check_outputs("coinc_start", 200, 800, 200, 400, 1, 0);
    frame_ticks(1);
    check_outputs("coinc_next", 204, 804, 202, 402, 1, 0);

    // asynchronous clear mid-line, between clock edges
    frame_ticks(10);
    @(posedge clk_65M);
    #2 clear = 1'b0;
    #1 check_outputs("clear_async", 200, 800, 200, 400, 0, 0);
    @(negedge clk_65M); clear = 1'b1;
    frame_ticks(2);
    check_outputs("after_clear_idle", 200, 800, 200, 400, 0, 0);

    // randomized sequence against the model, starting from idle at INIT
    set_on(1'b0);
    m_on = 1'b0; m_state = 0; mx = IX; my = IY; mdx = 1; mdy = 1;
    for (int t = 0; t < 200; t++) begin
      r  = $urandom_range(0, 9);
      eb = 1'b0;
      if (r <= 5) begin
        n = $urandom_range(1, 12);
        frame_ticks(n);
        for (int k = 0; k < n; k++) begin
          model_tick(h);
          eb = h;
        end
      end else if (r <= 7) begin
        m_on = !m_on;
        set_on(m_on);
        if (m_state == 1 && !m_on) m_state = 2;
        else if (m_state == 2 && m_on) m_state = 1;
      end else if (r == 8) begin
        start_pulse();
        model_start();
      end else begin
        start_with_tick();
        model_start();
      end
      check_outputs($sformatf("rnd%0d op%0d", t, r), mx, mx + RW, my, my + RH,
                    (m_state == 1) ? 1 : 0, eb ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
